// File: rtl/seq_tx_pkg.sv
// Shared encodings for the serial pattern transmitter and its "101" mirror tracker.
package seq_tx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        GAP   = 2'b10
    } tx_state_t;

    typedef enum logic [1:0] {
        S0 = 2'b00,
        S1 = 2'b01,
        S2 = 2'b10
    } trk_state_t;

    localparam logic [7:0] HIT_CNT_MAX = 8'd255;

endpackage

// File: rtl/seq101_tracker.sv
// Overlapping "101" detector: Mealy hit pulse plus a saturating hit counter.
// Advances on every clock edge, so idle zeros in the stream break partial matches.
module seq101_tracker
    import seq_tx_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       bit_in,
    output logic       hit_pulse,
    output logic [7:0] hit_count
);

    trk_state_t state, state_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S0;
        else     state <= state_nxt;
    end

    // S1 means "last bit was 1" and S2 means "last two bits were 10".
    always_comb begin
        state_nxt = state;
        hit_pulse = 1'b0;
        case (state)
            S0: state_nxt = bit_in ? S1 : S0;
            S1: state_nxt = bit_in ? S1 : S2;
            S2: begin
                state_nxt = bit_in ? S1 : S0;
                hit_pulse = bit_in;
            end
            default: state_nxt = S0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            hit_count <= 8'd0;
        else if (hit_pulse && (hit_count != HIT_CNT_MAX))
            hit_count <= hit_count + 8'd1;
    end

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: valid/ready word input, MSB-first bit stream out,
// with an internal "101" tracker giving the cycle-exact expected detector output.
module seq_pattern_tx
    import seq_tx_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int GAP_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             busy,
    output logic             done,
    output logic             hit_pulse,
    output logic [7:0]       hit_count
);

    // Handshake: a word transfers on a rising edge where in_valid && in_ready;
    // in_ready is a function of state and counters only, and in_data must be
    // held stable by the source for as long as in_valid is high.

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
    localparam logic [3:0] LAST_GAP = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;
    localparam bit BACK_TO_BACK = (GAP_CYCLES == 0);

    tx_state_t        state, state_nxt;
    logic [WIDTH-1:0] shreg, shreg_nxt;
    logic [CNT_W-1:0] bit_cnt, bit_cnt_nxt;
    logic [3:0]       gap_cnt, gap_cnt_nxt;
    logic             last_bit;
    logic             take;

    assign last_bit  = (state == SHIFT) && (bit_cnt == LAST_BIT);
    assign in_ready  = (state == IDLE) || (BACK_TO_BACK && last_bit);
    assign take      = in_valid && in_ready;

    assign ser_valid = (state == SHIFT);
    assign ser_out   = ser_valid && shreg[WIDTH-1];
    assign busy      = (state != IDLE);
    assign done      = last_bit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            gap_cnt <= '0;
        end else begin
            state   <= state_nxt;
            shreg   <= shreg_nxt;
            bit_cnt <= bit_cnt_nxt;
            gap_cnt <= gap_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        shreg_nxt   = shreg;
        bit_cnt_nxt = bit_cnt;
        gap_cnt_nxt = gap_cnt;
        case (state)
            IDLE: begin
                if (take) begin
                    shreg_nxt   = in_data;
                    bit_cnt_nxt = '0;
                    state_nxt   = SHIFT;
                end
            end
            SHIFT: begin
                shreg_nxt   = shreg << 1;
                bit_cnt_nxt = bit_cnt + 1'b1;
                if (last_bit) begin
                    bit_cnt_nxt = '0;
                    // A reload here only happens with no gap, giving a bubble-free stream.
                    if (take) begin
                        shreg_nxt = in_data;
                        state_nxt = SHIFT;
                    end else if (!BACK_TO_BACK) begin
                        gap_cnt_nxt = '0;
                        state_nxt   = GAP;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            GAP: begin
                gap_cnt_nxt = gap_cnt + 4'd1;
                if (gap_cnt == LAST_GAP) begin
                    gap_cnt_nxt = '0;
                    state_nxt   = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    seq101_tracker u_tracker (
        .clk       (clk),
        .rst       (rst),
        .bit_in    (ser_out),
        .hit_pulse (hit_pulse),
        .hit_count (hit_count)
    );

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Bench for seq_pattern_tx: one instance with a one-cycle gap and one back-to-back,
// each checked every cycle against a timeline model of the emitted bit stream.
module tb_seq_pattern_tx;

    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [1:0]     in_valid_a = 2'b00;
    logic [W-1:0]   in_data_a [2];
    int             cyc   = 0;
    int             total = 0;
    int             bad   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, exp, cyc);
        end
    endtask

    // Model: each accepted word becomes W timeline entries {cycle, last, bit};
    // any cycle without an entry must show an idle line.
    for (genvar d = 0; d < 2; d++) begin : mon
        localparam int G = (d == 0) ? 1 : 0;
        logic       in_ready, ser_out, ser_valid, busy, done, hit_pulse;
        logic [7:0] hit_count;
        logic [33:0] exp_q[$];
        int         last_cyc = -100;
        int         hits = 0;
        logic [1:0] hist = 2'b00;
        logic       hs = 1'b0;
        int         pending = 0;

        seq_pattern_tx #(.WIDTH(W), .GAP_CYCLES(G)) dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid_a[d]),
            .in_ready  (in_ready),
            .in_data   (in_data_a[d]),
            .ser_out   (ser_out),
            .ser_valid (ser_valid),
            .busy      (busy),
            .done      (done),
            .hit_pulse (hit_pulse),
            .hit_count (hit_count)
        );

        always @(negedge clk) begin
            logic       e_bit, e_valid, e_done, e_busy, e_ready, e_hit;
            logic [W-1:0] word;
            if (rst) begin
                exp_q.delete();
                last_cyc = -100;
                hits = 0;
                hist = 2'b00;
                hs = 1'b0;
                check("rst_ser_out", ser_out, 0);
                check("rst_ser_valid", ser_valid, 0);
                check("rst_done", done, 0);
                check("rst_busy", busy, 0);
                check("rst_in_ready", in_ready, 1);
                check("rst_hit_pulse", hit_pulse, 0);
                check("rst_hit_count", hit_count, 0);
            end else begin
                e_busy  = (cyc <= last_cyc + G);
                e_ready = !e_busy || ((G == 0) && (cyc == last_cyc));
                e_valid = 1'b0;
                e_bit   = 1'b0;
                e_done  = 1'b0;
                if (exp_q.size() > 0 && int'(exp_q[0][33:2]) == cyc) begin
                    e_valid = 1'b1;
                    e_done  = exp_q[0][1];
                    e_bit   = exp_q[0][0];
                    void'(exp_q.pop_front());
                end
                e_hit = (hist == 2'b10) && e_bit;
                check("ser_valid", ser_valid, e_valid);
                check("ser_out", ser_out, e_bit);
                check("done", done, e_done);
                check("busy", busy, e_busy);
                check("in_ready", in_ready, e_ready);
                check("hit_pulse", hit_pulse, e_hit);
                check("hit_count", hit_count, hits);
                if (e_hit && hits < 255) hits++;
                hist = {hist[0], e_bit};
                hs = in_valid_a[d] && e_ready;
                if (hs) begin
                    word = in_data_a[d];
                    for (int i = 0; i < W; i++)
                        exp_q.push_back({32'(cyc + 1 + i), (i == W - 1), word[W-1-i]});
                    last_cyc = cyc + W;
                end
            end
            pending = exp_q.size();
        end
    end

    function automatic logic hs_of(input int d);
        return (d == 0) ? mon[0].hs : mon[1].hs;
    endfunction

    function automatic int pending_of(input int d);
        return (d == 0) ? mon[0].pending : mon[1].pending;
    endfunction

    task automatic send(input int d, input logic [W-1:0] w);
        int n = 0;
        in_valid_a[d] = 1'b1;
        in_data_a[d]  = w;
        do begin
            @(posedge clk);
            n++;
        end while (!hs_of(d) && n < 100);
        check("handshake_wait", (n < 100), 1);
        #1;
        in_valid_a[d] = 1'b0;
    endtask

    task automatic wait_idle(input int d);
        int n = 0;
        while (pending_of(d) != 0 && n < 400) begin
            @(posedge clk);
            n++;
        end
        check("drain_wait", (n < 400), 1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic random_phase(input int d, input int words);
        for (int i = 0; i < words; i++) begin
            int k;
            k = $urandom_range(0, 3);
            in_data_a[d] = W'($urandom);
            repeat (k) @(posedge clk);
            if (k > 0) #1;
            send(d, W'($urandom));
        end
    endtask

    initial begin
        in_data_a[0] = '0;
        in_data_a[1] = '0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;

        // One-cycle gap: the gap zero breaks the cross-word 1,0,1.
        send(0, 8'h01);
        send(0, 8'h40);
        wait_idle(0);
        check("g1_pair_hits", mon[0].hit_count, 0);
        send(0, 8'hA5);
        wait_idle(0);
        check("g1_a5_hits", mon[0].hit_count, 2);

        // Abort mid-word with an asynchronous reset.
        send(0, 8'hFF);
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_ser_out", mon[0].ser_out, 0);
        check("abort_ser_valid", mon[0].ser_valid, 0);
        check("abort_busy", mon[0].busy, 0);
        check("abort_done", mon[0].done, 0);
        @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        send(0, 8'h5A);
        wait_idle(0);
        check("g1_5a_hits", mon[0].hit_count, 2);
        random_phase(0, 25);
        wait_idle(0);

        // Back-to-back: hit across the word boundary, then saturation.
        send(1, 8'h01);
        send(1, 8'h40);
        wait_idle(1);
        check("g0_pair_hits", mon[1].hit_count, 1);
        repeat (130) send(1, 8'hAA);
        wait_idle(1);
        check("g0_saturated", mon[1].hit_count, 255);
        random_phase(1, 25);
        wait_idle(1);
        check("g0_sat_hold", mon[1].hit_count, 255);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
